// File: rtl/timer_dev_pkg.sv
// Shared definitions for the countdown timer: register offsets, CTRL bit
// positions, MODE encodings and FSM states.
// Build option: define TIMER_PRESCALE_EN to widen CTRL with the PSC field.
package timer_dev_pkg;

   // Word offsets decoded from addr[3:2]
   localparam logic [1:0] TIMER_CTRL   = 2'd0;
   localparam logic [1:0] TIMER_PRESET = 2'd1;
   localparam logic [1:0] TIMER_COUNT  = 2'd2;

   // CTRL bit positions
   localparam int unsigned CTRL_EN      = 0;
   localparam int unsigned CTRL_MODE_LO = 1;
   localparam int unsigned CTRL_MODE_HI = 2;
   localparam int unsigned CTRL_IM      = 3;
   localparam int unsigned CTRL_PSC_LO  = 4;
   localparam int unsigned CTRL_PSC_HI  = 11;

`ifdef TIMER_PRESCALE_EN
   localparam int unsigned CTRL_W = 12;
`else
   localparam int unsigned CTRL_W = 4;
`endif

   // MODE encodings; 2'b1x behaves as one-shot
   typedef enum logic [1:0] {
      MODE_ONESHOT = 2'b00,
      MODE_RELOAD  = 2'b01
   } timer_mode_e;

   // Timer FSM states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      CNT  = 2'd2,
      INT  = 2'd3
   } timer_state_e;

endpackage

// File: rtl/timer_dev_byte_merge.sv
// Byte-lane merge of a write into an existing 32-bit word.
module timer_dev_byte_merge (
   input  logic [31:0] old_word,
   input  logic [31:0] wdata,
   input  logic [3:0]  byteen,
   output logic [31:0] merged_c
);

   // Each enabled lane takes wdata, the others keep the old word
   always_comb begin
      merged_c = old_word;
      for (int i = 0; i < 4; i++) begin
         if (byteen[i]) merged_c[8*i +: 8] = wdata[8*i +: 8];
      end
   end

endmodule

// File: rtl/timer_dev.sv
// Memory-mapped countdown timer: CTRL / PRESET / COUNT word registers and a
// registered interrupt request.
// Build option: TIMER_PRESCALE_EN adds a PSC field in CTRL[11:4] and a
// PRESC_W-bit prescaler that slows the COUNT decrement.
module timer_dev #(
   parameter int unsigned PRESC_W = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] addr,
   input  logic        we,
   input  logic [3:0]  byteen,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        irq
);
   import timer_dev_pkg::*;

   timer_state_e      state_q, state_d;
   logic [CTRL_W-1:0] ctrl_q, ctrl_d;
   logic [31:0]       preset_q, preset_d;
   logic [31:0]       count_q, count_d;
   logic              int_flag_q, int_flag_d;
   logic              irq_d;

   logic [1:0]  sel;
   logic        wr, ctrl_wr, preset_wr;
   logic [31:0] old_word, merged;
   logic        en, auto_reload;
   logic        int_set, int_clr, fsm_clr_en;
   logic        cnt_tick;
   logic        unused_addr;

   assign sel         = addr[3:2];
   assign unused_addr = ^{addr[31:4], addr[1:0]};
   assign wr          = we && (byteen != 4'b0000);
   assign ctrl_wr     = wr && (sel == TIMER_CTRL);
   assign preset_wr   = wr && (sel == TIMER_PRESET);
   assign en          = ctrl_q[CTRL_EN];
   assign auto_reload = (ctrl_q[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_RELOAD);
   assign old_word    = (sel == TIMER_CTRL) ? 32'(ctrl_q) : preset_q;

   timer_dev_byte_merge u_merge (
      .old_word (old_word),
      .wdata    (wdata),
      .byteen   (byteen),
      .merged_c (merged)
   );

   // Zero-latency read mux
   always_comb begin
      rdata = '0;
      case (sel)
         TIMER_CTRL:   rdata = 32'(ctrl_q);
         TIMER_PRESET: rdata = preset_q;
         TIMER_COUNT:  rdata = count_q;
         default:      rdata = '0;
      endcase
   end

`ifdef TIMER_PRESCALE_EN
   logic [PRESC_W-1:0] presc_q, presc_d;

   assign cnt_tick = (presc_q == PRESC_W'(ctrl_q[CTRL_PSC_HI:CTRL_PSC_LO]));

   // Prescaler restarts on LOAD and wraps to 0 each time it permits a decrement
   always_comb begin
      presc_d = presc_q;
      if (state_q == LOAD) begin
         presc_d = '0;
      end else if (state_q == CNT && en && count_q != 32'd0) begin
         presc_d = cnt_tick ? '0 : presc_q + PRESC_W'(1);
      end
   end

   // Prescaler register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) presc_q <= '0;
      else       presc_q <= presc_d;
   end
`else
   logic [PRESC_W-1:0] presc_unused;

   assign presc_unused = '0;
   assign cnt_tick     = 1'b1;
`endif

   // FSM state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next state, COUNT update and FSM-side flag/enable requests
   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      int_set    = 1'b0;
      int_clr    = 1'b0;
      fsm_clr_en = 1'b0;
      case (state_q)
         IDLE: begin
            if (en) state_d = LOAD;
         end
         LOAD: begin
            count_d = preset_q;
            state_d = CNT;
         end
         CNT: begin
            if (!en) begin
               state_d = IDLE;
            end else if (count_q == 32'd0) begin
               state_d = INT;
               int_set = 1'b1;
            end else if (cnt_tick) begin
               count_d = count_q - 32'd1;
            end
         end
         INT: begin
            if (auto_reload) begin
               state_d = LOAD;
               int_clr = 1'b1;
            end else begin
               state_d    = IDLE;
               fsm_clr_en = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Register next values; a CPU CTRL write overrides the FSM clearing EN
   always_comb begin
      ctrl_d = ctrl_q;
      if (ctrl_wr)         ctrl_d = merged[CTRL_W-1:0];
      else if (fsm_clr_en) ctrl_d[CTRL_EN] = 1'b0;

      preset_d = preset_q;
      if (preset_wr) preset_d = merged;

      int_flag_d = int_flag_q;
      if (int_set)      int_flag_d = 1'b1;
      else if (ctrl_wr) int_flag_d = 1'b0;
      else if (int_clr) int_flag_d = 1'b0;

      irq_d = int_flag_d & ctrl_d[CTRL_IM];
   end

   // Register file, interrupt flag and irq output
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ctrl_q     <= '0;
         preset_q   <= '0;
         count_q    <= '0;
         int_flag_q <= 1'b0;
         irq        <= 1'b0;
      end else begin
         ctrl_q     <= ctrl_d;
         preset_q   <= preset_d;
         count_q    <= count_d;
         int_flag_q <= int_flag_d;
         irq        <= irq_d;
      end
   end

endmodule

// File: tb/tb_timer_dev.sv
// Directed self-checking bench for timer_dev (default build).
module tb_timer_dev;
   import timer_dev_pkg::*;

   logic        clk;
   logic        reset;
   logic [31:0] addr;
   logic        we;
   logic [3:0]  byteen;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        irq;

   int pass_cnt  = 0;
   int total_cnt = 0;

   timer_dev dut (
      .clk    (clk),
      .reset  (reset),
      .addr   (addr),
      .we     (we),
      .byteen (byteen),
      .wdata  (wdata),
      .rdata  (rdata),
      .irq    (irq)
   );

   // Free-running clock, posedge at 5, 15, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) begin
         pass_cnt++;
      end else begin
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Present one write for a cycle; returns at the negedge after it lands
   task automatic wr(input logic [1:0] s, input logic [31:0] d, input logic [3:0] be);
      addr   = {28'd0, s, 2'b00};
      wdata  = d;
      byteen = be;
      we     = 1'b1;
      @(negedge clk);
      we     = 1'b0;
      byteen = 4'b0000;
   endtask

   task automatic rd_chk(input string tag, input logic [1:0] s, input logic [31:0] exp);
      addr = {28'd0, s, 2'b00};
      #1;
      chk(tag, rdata, exp);
   endtask

   // Directed sequence; cycle 0 is the first cycle after a write lands
   initial begin
      reset  = 1'b1;
      addr   = '0;
      we     = 1'b0;
      byteen = 4'b0000;
      wdata  = '0;
      repeat (2) @(negedge clk);
      rd_chk("rst_ctrl", TIMER_CTRL, 32'h0);
      rd_chk("rst_preset", TIMER_PRESET, 32'h0);
      rd_chk("rst_count", TIMER_COUNT, 32'h0);
      chk("rst_irq", 32'(irq), 32'h0);
      chk("rst_state", 32'(dut.state_q), 32'(IDLE));
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // One-shot, PRESET=3: COUNT 3..0 in cycles 2..5, irq in cycle 6
      wr(TIMER_PRESET, 32'd3, 4'hF);
      wr(TIMER_CTRL, 32'h9, 4'hF);
      for (int c = 0; c <= 6; c++) begin
         chk("os_irq", 32'(irq), 32'(c == 6));
         if (c >= 2 && c <= 5) rd_chk("os_count", TIMER_COUNT, 32'(5 - c));
         if (c < 6) @(negedge clk);
      end
      @(negedge clk);
      rd_chk("os_ctrl_en_cleared", TIMER_CTRL, 32'h8);
      chk("os_irq_held", 32'(irq), 32'h1);
      chk("os_state_idle", 32'(dut.state_q), 32'(IDLE));
      wr(TIMER_CTRL, 32'h8, 4'hF);
      @(negedge clk);
      chk("os_irq_cleared", 32'(irq), 32'h0);

      // PRESET=0: LOAD in cycle 1, INT (irq) in cycle 3
      wr(TIMER_PRESET, 32'd0, 4'hF);
      wr(TIMER_CTRL, 32'h9, 4'hF);
      for (int c = 0; c <= 3; c++) begin
         chk("p0_irq", 32'(irq), 32'(c == 3));
         if (c < 3) @(negedge clk);
      end
      wr(TIMER_CTRL, 32'h8, 4'hF);
      @(negedge clk);
      chk("p0_irq_cleared", 32'(irq), 32'h0);
      chk("p0_state_idle", 32'(dut.state_q), 32'(IDLE));

      // Auto-reload, PRESET=2: one-cycle irq pulse every 5 cycles
      wr(TIMER_PRESET, 32'd2, 4'hF);
      wr(TIMER_CTRL, 32'hB, 4'hF);
      for (int c = 0; c <= 21; c++) begin
         chk("ar_irq", 32'(irq), 32'(c >= 5 && (c % 5) == 0));
         @(negedge clk);
      end
      wr(TIMER_CTRL, 32'h0, 4'hF);
      repeat (2) @(negedge clk);
      chk("ar_stop_idle", 32'(dut.state_q), 32'(IDLE));

      // Byte enables
      wr(TIMER_PRESET, 32'h11223344, 4'hF);
      wr(TIMER_PRESET, 32'hAABBCCDD, 4'b0101);
      rd_chk("be_merge", TIMER_PRESET, 32'h11BB33DD);
      wr(TIMER_PRESET, 32'hFFFFFFFF, 4'b0000);
      rd_chk("be_none", TIMER_PRESET, 32'h11BB33DD);
      wr(TIMER_CTRL, 32'hFFFFFFF0, 4'hF);
      rd_chk("ctrl_upper_zero", TIMER_CTRL, 32'h0);

      // Masked expiry: irq stays low, EN still cleared by one-shot
      wr(TIMER_PRESET, 32'd1, 4'hF);
      wr(TIMER_CTRL, 32'h1, 4'hF);
      for (int c = 0; c <= 7; c++) begin
         chk("mask_irq", 32'(irq), 32'h0);
         @(negedge clk);
      end
      rd_chk("mask_ctrl", TIMER_CTRL, 32'h0);
      chk("mask_flag_set", 32'(dut.int_flag_q), 32'h1);

      // Stop mid-count: EN drops as COUNT becomes 2, COUNT holds 2
      wr(TIMER_PRESET, 32'd5, 4'hF);
      wr(TIMER_CTRL, 32'h1, 4'hF);
      repeat (4) @(negedge clk);
      rd_chk("stop_count_pre", TIMER_COUNT, 32'd3);
      wr(TIMER_CTRL, 32'h0, 4'hF);
      repeat (2) @(negedge clk);
      rd_chk("stop_count_hold", TIMER_COUNT, 32'd2);
      chk("stop_state_idle", 32'(dut.state_q), 32'(IDLE));
      wr(TIMER_COUNT, 32'hFFFFFFFF, 4'hF);
      rd_chk("count_wr_ignored", TIMER_COUNT, 32'd2);
      wr(2'd3, 32'hFFFFFFFF, 4'hF);
      rd_chk("reserved_zero", 2'd3, 32'h0);

      // Collision: CTRL write in the INT cycle keeps EN and reloads
      wr(TIMER_PRESET, 32'd3, 4'hF);
      wr(TIMER_CTRL, 32'h9, 4'hF);
      repeat (6) @(negedge clk);
      chk("col_state_int", 32'(dut.state_q), 32'(INT));
      chk("col_irq", 32'(irq), 32'h1);
      wr(TIMER_CTRL, 32'h9, 4'hF);
      rd_chk("col_ctrl_en_kept", TIMER_CTRL, 32'h9);
      @(negedge clk);
      chk("col_state_load", 32'(dut.state_q), 32'(LOAD));
      @(negedge clk);
      rd_chk("col_count_reload", TIMER_COUNT, 32'd3);
      chk("col_state_cnt", 32'(dut.state_q), 32'(CNT));
      wr(TIMER_CTRL, 32'h0, 4'hF);
      repeat (2) @(negedge clk);

      // Reset mid-count takes effect without a clock edge
      wr(TIMER_PRESET, 32'd5, 4'hF);
      wr(TIMER_CTRL, 32'h9, 4'hF);
      repeat (3) @(negedge clk);
      rd_chk("mid_count_pre", TIMER_COUNT, 32'd4);
      #1;
      reset = 1'b1;
      #1;
      chk("mid_irq", 32'(irq), 32'h0);
      chk("mid_state", 32'(dut.state_q), 32'(IDLE));
      rd_chk("mid_ctrl", TIMER_CTRL, 32'h0);
      rd_chk("mid_preset", TIMER_PRESET, 32'h0);
      rd_chk("mid_count", TIMER_COUNT, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
